// File: rtl/ifetch.sv
// Instruction fetch: holds the PC, reads imem every cycle and queues {pc, instr, fault} entries for decode.
// Latency: an instruction fetched in cycle N is at the queue head in cycle N+1; a redirect in N yields output in N+2.
// Backpressure: valid/ready on the out_* side; a full queue without a pop stalls the PC, so nothing is lost or duplicated.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   imem_addr, imem_word     byte address (pc[9:0]) and constant 32-bit access size to imem
//   imem_data                imem read data; only [31:0] is consumed
//   redirect_valid/_pc       load a new PC, flushing the queue and leaving HALT
//   out_valid/_ready         head-of-queue handshake towards decode
//   out_pc/_instr/_fault     head entry, forced to zero when the queue is empty

module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  imem_addr,
    output logic [1:0]  imem_word,
    input  logic [63:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic [1:0]  out_fault
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_MISAL = 2'b01;
    localparam logic [1:0] FAULT_ACC   = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    // Entry storage; contents are only meaningful under count_q, so no reset needed.
    logic [63:0]     q_pc_q    [QDEPTH];
    logic [31:0]     q_instr_q [QDEPTH];
    logic [1:0]      q_fault_q [QDEPTH];

    logic            fetch_en;
    logic            pop;
    logic            push;
    logic [1:0]      fault_code;
    logic [31:0]     wr_instr;
    logic            unused_imem_hi;

    assign unused_imem_hi = ^imem_data[63:32];

    assign imem_addr = pc_q[9:0];
    assign imem_word = 2'b10;

    // Misalignment wins over the out-of-range check.
    always_comb begin
        fault_code = FAULT_NONE;
        if (pc_q[1:0] != 2'b00) begin
            fault_code = FAULT_MISAL;
        end else if (pc_q[63:10] != 54'd0) begin
            fault_code = FAULT_ACC;
        end
    end

    assign wr_instr = (fault_code == FAULT_NONE) ? imem_data[31:0] : 32'h0;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
        end else if (push && (fault_code != FAULT_NONE)) begin
            state_d = ST_HALT;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fetch_en  = (state_q == ST_RUN);
        out_valid = (count_q != '0);
        out_pc    = 64'h0;
        out_instr = 32'h0;
        out_fault = 2'b00;
        if (out_valid) begin
            out_pc    = q_pc_q[rd_ptr_q];
            out_instr = q_instr_q[rd_ptr_q];
            out_fault = q_fault_q[rd_ptr_q];
        end
    end

    assign pop  = out_valid & out_ready;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop);

    // ---------------- PC and queue bookkeeping ----------------
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            // Flush: any concurrent pop is consumed along with the rest.
            pc_d     = redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push && (fault_code == FAULT_NONE)) begin
                pc_d = pc_q + 64'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_instr_q[wr_ptr_q] <= wr_instr;
            q_fault_q[wr_ptr_q] <= fault_code;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed test-plan scenarios with literal expectations, then randomized traffic.
// Latency: every cycle the DUT outputs are compared against a queue-based model at the falling edge.
// Backpressure: out_ready is driven both held-low and randomly to exercise full-queue stalls.

module tb_ifetch;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr;
    logic [1:0]  imem_word;
    logic [63:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  out_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic [31:0] hi_rand = 32'h0;

    assign imem_data = {hi_rand, mem[imem_addr[9:2]]};

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(64'h0), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_word      (imem_word),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    bit          m_halted;

    function automatic logic [1:0] classify(input logic [63:0] a);
        if (a % 4 != 0)       return 2'b01;
        if (a > 64'd1020)     return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = 64'h0;
        m_halted = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        ent_t e;
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (redirect_valid) begin
            mq.delete();
            m_pc     = redirect_pc;
            m_halted = 0;
        end else if (!m_halted && mq.size() < QD) begin
            e.pc    = m_pc;
            e.fault = classify(m_pc);
            e.instr = (e.fault == 2'b00) ? mem[m_pc[9:2]] : 32'h0;
            mq.push_back(e);
            if (e.fault != 2'b00) m_halted = 1;
            else                  m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        ent_t h;
        h.pc = 64'h0; h.instr = 32'h0; h.fault = 2'b00;
        if (mq.size() != 0) h = mq[0];
        chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("m_out_pc",    out_pc,         h.pc);
        chk("m_out_instr", 64'(out_instr), 64'(h.instr));
        chk("m_out_fault", 64'(out_fault), 64'(h.fault));
        chk("m_imem_addr", 64'(imem_addr), 64'(m_pc[9:0]));
        chk("m_imem_word", 64'(imem_word), 64'd2);
    endtask

    // Called at posedge+1: drive inputs, compare at negedge, step model, return at next posedge+1.
    task automatic cycle(input bit rv, input logic [63:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        hi_rand        = $urandom;
        @(negedge clk);
        compare_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_out_pc",    out_pc,         64'd0);
        model_reset();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [63:0] rpc_r;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h00100093;
        mem[1] = 32'h00200113;
        mem[2] = 32'h002081b3;
        model_reset();

        // Reset state
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_instr", 64'(out_instr), 64'd0);
        chk("reset_out_fault", 64'(out_fault), 64'd0);
        chk("reset_imem_addr", 64'(imem_addr), 64'd0);
        chk("reset_imem_word", 64'(imem_word), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential fetch
        cycle(0, 0, 1);
        chk("seq0_valid", 64'(out_valid), 64'd1);
        chk("seq0_pc",    out_pc, 64'h0);
        chk("seq0_instr", 64'(out_instr), 64'h00100093);
        cycle(0, 0, 1);
        chk("seq1_pc",    out_pc, 64'h4);
        chk("seq1_instr", 64'(out_instr), 64'h00200113);
        cycle(0, 0, 1);
        chk("seq2_pc",    out_pc, 64'h8);
        chk("seq2_instr", 64'(out_instr), 64'h002081b3);

        // Backpressure
        async_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_head",  out_pc, 64'h0);
        chk("bp_addr",  64'(imem_addr), 64'h8);
        cycle(0, 0, 1);
        chk("bp_pc4",  out_pc, 64'h4);
        cycle(0, 0, 1);
        chk("bp_pc8",  out_pc, 64'h8);
        cycle(0, 0, 1);
        chk("bp_pc12", out_pc, 64'hc);

        // Redirect flush
        async_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("rd_pre_head", out_pc, 64'h0);
        cycle(1, 64'h40, 0);
        chk("rd_flush_valid", 64'(out_valid), 64'd0);
        cycle(0, 0, 1);
        chk("rd_valid", 64'(out_valid), 64'd1);
        chk("rd_pc",    out_pc, 64'h40);
        chk("rd_instr", 64'(out_instr), 64'(mem[16]));

        // Misaligned redirect
        cycle(1, 64'h42, 1);
        cycle(0, 0, 1);
        chk("mis_pc",    out_pc, 64'h42);
        chk("mis_instr", 64'(out_instr), 64'h0);
        chk("mis_fault", 64'(out_fault), 64'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            chk("mis_halt_valid", 64'(out_valid), 64'd0);
            chk("mis_halt_addr",  64'(imem_addr), 64'h42);
        end
        cycle(1, 64'h10, 1);
        cycle(0, 0, 1);
        chk("mis_resume_pc",    out_pc, 64'h10);
        chk("mis_resume_instr", 64'(out_instr), 64'(mem[4]));

        // Access fault at the boundary
        cycle(1, 64'h3fc, 1);
        cycle(0, 0, 1);
        chk("bnd_pc",    out_pc, 64'h3fc);
        chk("bnd_instr", 64'(out_instr), 64'(mem[255]));
        chk("bnd_fault", 64'(out_fault), 64'h0);
        cycle(0, 0, 1);
        chk("acc_pc",    out_pc, 64'h400);
        chk("acc_instr", 64'(out_instr), 64'h0);
        chk("acc_fault", 64'(out_fault), 64'h2);
        cycle(0, 0, 1);
        chk("acc_halt_valid", 64'(out_valid), 64'd0);
        cycle(0, 0, 1);
        chk("acc_halt_valid2", 64'(out_valid), 64'd0);

        // Async reset mid-stream with a full queue
        cycle(1, 64'h80, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        chk("ar_pre_addr",  64'(imem_addr), 64'h88);
        #3;
        async_reset();
        cycle(0, 0, 1);
        chk("ar_first_pc",    out_pc, 64'h0);
        chk("ar_first_instr", 64'(out_instr), 64'h00100093);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0: rpc_r = 64'($urandom_range(0, 255)) * 4;
                1: rpc_r = 64'($urandom_range(0, 1023));
                2: rpc_r = 64'h3f0 + 64'($urandom_range(0, 3)) * 4;
                3: rpc_r = {32'($urandom), 32'($urandom)};
                default: rpc_r = 64'($urandom_range(0, 63)) * 4;
            endcase
            cycle(($urandom_range(0, 11) == 0), rpc_r, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage directly upstream of `imem`. Holds the program counter, drives `imem` with a 32-bit read each cycle, and captures {pc, instruction, fault} entries into a small in-order queue. Decode drains the queue through a valid/ready handshake. Execute redirects fetch on taken branches, jumps and traps.

## Interface
- `RESET_PC`, 64'h0: PC value loaded on reset.
- `QDEPTH`, 2: fetch queue entries; must be a power of two, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  10  byte address to `imem`; equals `pc[9:0]`.
- `imem_word`  out  2  access size to `imem`; constant 2'b10 (32-bit).
- `imem_data`  in  64  read data from `imem`; only `[31:0]` is used.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  64  redirect target.
- `out_valid`  out  1  queue head is valid.
- `out_ready`  in  1  decode accepts the head.
- `out_pc`  out  64  PC of the head entry.
- `out_instr`  out  32  instruction of the head entry.
- `out_fault`  out  2  fault code: 00 none, 01 misaligned, 10 access fault.

## Operation
- State machine has two states:
  - RUN: fetch is active.
  - HALT: a fault entry has been queued; fetch is stopped.
- Fault classification of `pc`, evaluated combinationally each cycle:
  - `pc[1:0] != 0` gives misaligned (01). This has priority.
  - Otherwise `pc[63:10] != 0` gives access fault (10).
  - Otherwise no fault (00). Addresses 0..1020 word-aligned are legal; `imem` reads bytes addr..addr+3.
- Pop condition: `pop = out_valid & out_ready`.
- Push condition: `push = (state==RUN) & ~redirect_valid & (count<QDEPTH | pop)`.
- On push with no fault:
  - enqueue {pc, `imem_data[31:0]`, 00};
  - `pc <= pc + 4`, modulo 2^64.
- On push with a fault:
  - enqueue {pc, 32'h0, code};
  - pc holds;
  - state goes to HALT.
- On redirect (has priority over push):
  - a pop handshake in the same cycle still counts as consumed;
  - all queue entries are then discarded, so count becomes 0;
  - `pc <= redirect_pc`;
  - state goes to RUN, including from HALT.
- In HALT without a redirect: no push; pc holds; queued entries still drain normally.
- Full queue with no pop: no push, pc holds, and `imem_addr` keeps pointing at the same word.
- Push and pop in the same cycle on a full queue are legal; count stays at QDEPTH.
- Output gating:
  - `out_valid = (count != 0)`;
  - `out_pc`, `out_instr` and `out_fault` show the head entry when `out_valid` is 1, and are forced to 0 otherwise.
- Outputs come from registers only. There is no combinational path from `imem_data`, `redirect_*` or `out_ready` to any `out_*` signal.
- Reset values:
  - pc = RESET_PC, queue empty, state RUN;
  - `out_valid`, `out_pc`, `out_instr`, `out_fault` all 0;
  - `imem_addr = RESET_PC[9:0]`, `imem_word = 2'b10`.
- Reset asserted mid-operation clears everything immediately and asynchronously. Fetch resumes at RESET_PC on the first edge after deassertion.

## Timing
- Fetch-to-output latency: an instruction fetched in cycle N appears at the head with `out_valid=1` in cycle N+1, provided the queue was empty.
- Throughput: one instruction per cycle while decode holds `out_ready=1`.
- Redirect-to-output latency: redirect in cycle N, fetch at `redirect_pc` in N+1, `out_valid` in N+2.
- After reset deassertion: first fetch in the first cycle; `out_valid=1` one cycle later.
- Backpressure: with `out_ready=0`, exactly QDEPTH entries are captured, then pc stalls. No instruction is lost or duplicated when `out_ready` returns.

## Test plan
- Sequential fetch:
  - imem words at 0,4,8 = 0x00100093, 0x00200113, 0x002081b3;
  - with `out_ready=1`, the bench sees (pc,instr) = (0,0x00100093), (4,0x00200113), (8,0x002081b3) on consecutive cycles, starting one cycle after reset release.
- Backpressure:
  - hold `out_ready=0` for 5 cycles from reset;
  - `out_valid=1` with head pc 0, and `imem_addr` stays at 8;
  - after release, pcs 0,4,8,12 appear in order with no gaps.
- Redirect flush:
  - with entries pc 0 and 4 queued, pulse `redirect_valid` with `redirect_pc=0x40`;
  - `out_valid=0` in the following cycle;
  - the next output is pc 0x40 with imem word 0x40, two cycles after the redirect.
- Misaligned redirect:
  - `redirect_pc=0x42`;
  - expect a single entry {0x42, 0, 01}, then no further entries and `imem_addr` constant;
  - a later redirect to 0x10 resumes fetch at 0x10.
- Access fault at the boundary:
  - redirect to 0x3FC;
  - expect entry {0x3FC, mem word, 00}, then entry {0x400, 0, 10}, then HALT.
- Async reset mid-stream:
  - assert `rst` between clock edges while the queue is full;
  - `out_valid` drops to 0 immediately and `imem_addr` becomes RESET_PC[9:0];
  - after release, pc 0 is output first.
